// File: rtl/local_fc_scheduler.sv
// TX frame scheduler: turns local RX FIFO occupancy into XOFF/XON control frames
// and merges them, at priority, with user data. Optional refresh: FC_REFRESH_EN.
module local_fc_scheduler #(
   parameter int unsigned FRAME_WIDTH    = 256,
   parameter int unsigned CRC_WIDTH      = 12,
   parameter int unsigned OCC_WIDTH      = 10,
   parameter int unsigned HI_THRESH      = 768,
   parameter int unsigned LO_THRESH      = 256,
   parameter int unsigned REFRESH_CYCLES = 4096
) (
   input  logic                   tx_frame_clk,
   input  logic                   rst_n,
   input  logic [OCC_WIDTH-1:0]   rx_occupancy,
   input  logic                   remote_fc,
   input  logic [FRAME_WIDTH-1:0] user_frame,
   input  logic                   user_valid,
   output logic                   user_ready,
   output logic [FRAME_WIDTH-1:0] tx_frame,
   output logic                   tx_valid,
   input  logic                   tx_ready,
   output logic                   local_fc
);

   typedef enum logic [1:0] {RELEASED, PAUSE_PEND, PAUSED, RELEASE_PEND} state_t;

   localparam logic [OCC_WIDTH-1:0] HI      = OCC_WIDTH'(HI_THRESH);
   localparam logic [OCC_WIDTH-1:0] LO      = OCC_WIDTH'(LO_THRESH);
   localparam logic [7:0]           KEY_ON  = 8'h01;
   localparam logic [7:0]           KEY_OFF = 8'h02;

   state_t                   state, state_next;
   logic                     load_en, occ_hi, occ_lo;
   logic                     refresh_due, ctrl_pending, send_ctrl;
   logic [7:0]               ctrl_key;
   logic [FRAME_WIDTH-1:0]   ctrl_frame;

   assign load_en = !tx_valid || tx_ready;
   assign occ_hi  = rx_occupancy >= HI;
   assign occ_lo  = rx_occupancy <= LO;

   always_ff @(posedge tx_frame_clk or negedge rst_n) begin
      if (!rst_n) state <= RELEASED;
      else        state <= state_next;
   end

   // A threshold reversal before the pending frame goes out cancels it.
   always_comb begin
      state_next = state;
      case (state)
         RELEASED:     if (occ_hi) state_next = PAUSE_PEND;
         PAUSE_PEND:   if (occ_lo) state_next = RELEASED;
                       else if (load_en) state_next = PAUSED;
         PAUSED:       if (occ_lo) state_next = RELEASE_PEND;
         RELEASE_PEND: if (occ_hi) state_next = PAUSED;
                       else if (load_en) state_next = RELEASED;
         default:      state_next = RELEASED;
      endcase
   end

   // ctrl_pending uses registered state only, so user_ready never sees occupancy.
   always_comb begin
      ctrl_pending = 1'b0;
      send_ctrl    = 1'b0;
      ctrl_key     = '0;
      case (state)
         PAUSE_PEND: begin
            ctrl_pending = 1'b1;
            send_ctrl    = !occ_lo;
            ctrl_key     = KEY_ON;
         end
         RELEASE_PEND: begin
            ctrl_pending = 1'b1;
            send_ctrl    = !occ_hi;
            ctrl_key     = KEY_OFF;
         end
         PAUSED: begin
            ctrl_pending = refresh_due;
            send_ctrl    = refresh_due && !occ_lo;
            ctrl_key     = KEY_ON;
         end
         default: begin
            ctrl_pending = refresh_due;
            send_ctrl    = refresh_due && !occ_hi;
            ctrl_key     = KEY_OFF;
         end
      endcase
      ctrl_frame                 = '0;
      ctrl_frame[CRC_WIDTH +: 8] = ctrl_key;
   end

   assign user_ready = rst_n && load_en && !ctrl_pending && !remote_fc;

   always_ff @(posedge tx_frame_clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_frame <= '0;
         tx_valid <= 1'b0;
         local_fc <= 1'b0;
      end else if (load_en) begin
         if (send_ctrl) begin
            tx_frame <= ctrl_frame;
            tx_valid <= 1'b1;
            local_fc <= (ctrl_key == KEY_ON);
         end else if (user_valid && user_ready) begin
            tx_frame <= user_frame;
            tx_valid <= 1'b1;
         end else begin
            tx_valid <= 1'b0;
         end
      end
   end

`ifdef FC_REFRESH_EN
   localparam int unsigned     CNT_W    = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_CYCLES - 1);

   logic [CNT_W-1:0] refresh_cnt;

   // Counter parks at its last value until the re-send is actually loaded.
   always_ff @(posedge tx_frame_clk or negedge rst_n) begin
      if (!rst_n) begin
         refresh_cnt <= '0;
      end else if (state_next != state) begin
         refresh_cnt <= '0;
      end else if (state == RELEASED || state == PAUSED) begin
         if (load_en && send_ctrl)       refresh_cnt <= '0;
         else if (refresh_cnt != CNT_LAST) refresh_cnt <= refresh_cnt + 1'b1;
      end
   end

   assign refresh_due = (state == RELEASED || state == PAUSED) && (refresh_cnt == CNT_LAST);
`else
   logic cfg_unused;
   assign cfg_unused  = (REFRESH_CYCLES == 0);
   assign refresh_due = 1'b0;
`endif

endmodule

// File: tb/tb_local_fc_scheduler.sv
// Directed bench for local_fc_scheduler: threshold crossings, arbitration against
// user traffic, backpressure hold, remote pause, cancellation, reset and refresh.
module tb_local_fc_scheduler;

   localparam logic [255:0] ON  = 256'h1000;
   localparam logic [255:0] OFF = 256'h2000;

   logic         clk, rst_n;
   logic [9:0]   occ;
   logic         remote_fc, user_valid, user_ready, tx_valid, tx_ready, local_fc;
   logic [255:0] user_frame, tx_frame;

   int unsigned  n_checks = 0;
   int unsigned  n_pass   = 0;
   logic [255:0] got[$];
   logic [255:0] exp_q[$];
   int unsigned  seq, n_ref, exp_ref;
   logic         acc;

   local_fc_scheduler #(
      .FRAME_WIDTH(256), .CRC_WIDTH(12), .OCC_WIDTH(10),
      .HI_THRESH(768), .LO_THRESH(256), .REFRESH_CYCLES(16)
   ) dut (
      .tx_frame_clk(clk), .rst_n(rst_n), .rx_occupancy(occ), .remote_fc(remote_fc),
      .user_frame(user_frame), .user_valid(user_valid), .user_ready(user_ready),
      .tx_frame(tx_frame), .tx_valid(tx_valid), .tx_ready(tx_ready), .local_fc(local_fc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk)
      if (rst_n && tx_valid && tx_ready) got.push_back(tx_frame);

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   function automatic logic [255:0] uf(input int unsigned n);
      return (256'h1 << 252) | 256'(n);
   endfunction

   task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
   endtask

   task automatic check_stream(input string tag);
      check({tag, "_count"}, 256'(got.size()), 256'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++)
         check(tag, (i < got.size()) ? got[i] : '1, exp_q[i]);
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   initial begin
      rst_n = 1'b0; occ = '0; remote_fc = 1'b0; user_valid = 1'b0;
      user_frame = '0; tx_ready = 1'b1;
      step(); step();
      check("rst_tx_valid",   256'(tx_valid),   256'd0);
      check("rst_tx_frame",   tx_frame,         256'd0);
      check("rst_local_fc",   256'(local_fc),   256'd0);
      check("rst_user_ready", 256'(user_ready), 256'd0);
      rst_n = 1'b1;

      // threshold ramp up and down
      occ = 10'd700; step(); check("below_hi_700", 256'(tx_valid), 256'd0);
      occ = 10'd767; step(); check("below_hi_767", 256'(tx_valid), 256'd0);
      occ = 10'd768; step(); check("cross_hi_latency", 256'(tx_valid), 256'd0);
      check("ctrl_blocks_ready", 256'(user_ready), 256'd0);
      step();
      check("fc_on_valid", 256'(tx_valid), 256'd1);
      check("fc_on_frame", tx_frame, ON);
      check("local_fc_set", 256'(local_fc), 256'd1);
      step(); check("fc_on_once", 256'(tx_valid), 256'd0);
      occ = 10'd500; step(); check("hyst_500", 256'(tx_valid), 256'd0);
      occ = 10'd257; step(); check("hyst_257", 256'(tx_valid), 256'd0);
      check("local_fc_held", 256'(local_fc), 256'd1);
      occ = 10'd256; step(); check("cross_lo_latency", 256'(tx_valid), 256'd0);
      step();
      check("fc_off_valid", 256'(tx_valid), 256'd1);
      check("fc_off_frame", tx_frame, OFF);
      check("local_fc_clr", 256'(local_fc), 256'd0);
      step(); check("fc_off_once", 256'(tx_valid), 256'd0);

      // FC_ON inserted into a continuous user stream
      got.delete(); seq = 0;
      for (int c = 0; c < 8; c++) begin
         if (c == 3) occ = 10'd800;
         user_valid = 1'b1; user_frame = uf(seq); #1;
         if (c == 4) check("user_stall_for_fc", 256'(user_ready), 256'd0);
         acc = user_ready;
         step();
         if (acc) seq++;
      end
      user_valid = 1'b0; step(); step();
      exp_q = '{uf(0), uf(1), uf(2), uf(3), ON, uf(4), uf(5), uf(6)};
      check_stream("stream_insert");

      // backpressure while FC_ON pending
      occ = 10'd100; step(); step(); step();
      check("release_before_hold", 256'(local_fc), 256'd0);
      got.delete();
      user_valid = 1'b1; user_frame = uf(20); occ = 10'd0; tx_ready = 1'b1; step();
      user_frame = uf(21); tx_ready = 1'b0; occ = 10'd800;
      for (int c = 0; c < 5; c++) begin
         step();
         check("hold_valid", 256'(tx_valid), 256'd1);
         check("hold_frame", tx_frame, uf(20));
      end
      tx_ready = 1'b1; step(); step();
      user_valid = 1'b0; step(); step();
      exp_q = '{uf(20), ON, uf(21)};
      check_stream("stream_hold");

      // remote pause blocks user data but not FC
      occ = 10'd100; step(); step(); step();
      remote_fc = 1'b1; user_valid = 1'b1; user_frame = uf(30); occ = 10'd0; #1;
      check("remote_blocks_ready", 256'(user_ready), 256'd0);
      step(); check("remote_blocks_data", 256'(tx_valid), 256'd0);
      occ = 10'd800; step(); step();
      check("remote_fc_on_valid", 256'(tx_valid), 256'd1);
      check("remote_fc_on_frame", tx_frame, ON);
      step(); check("remote_still_blocks", 256'(tx_valid), 256'd0);
      remote_fc = 1'b0; #1;
      check("remote_clear_ready", 256'(user_ready), 256'd1);
      step();
      check("remote_clear_valid", 256'(tx_valid), 256'd1);
      check("remote_clear_frame", tx_frame, uf(30));
      user_valid = 1'b0; step();

      // crossing reversed before the FC_ON could leave
      occ = 10'd100; step(); step(); step();
      user_valid = 1'b1; user_frame = uf(40); tx_ready = 1'b1; step();
      user_valid = 1'b0; tx_ready = 1'b0; occ = 10'd800; step(); step();
      occ = 10'd200; step();
      check("cancel_local_fc", 256'(local_fc), 256'd0);
      check("cancel_frame_held", tx_frame, uf(40));
      got.delete();
      tx_ready = 1'b1; step(); step(); step();
      exp_q = '{uf(40)};
      check_stream("stream_cancel");
      check("cancel_local_fc_after", 256'(local_fc), 256'd0);

      // asynchronous reset drops the in-flight frame
      user_valid = 1'b1; user_frame = uf(50); tx_ready = 1'b0; occ = 10'd0; step();
      check("pre_reset_valid", 256'(tx_valid), 256'd1);
      rst_n = 1'b0; #1;
      check("async_rst_valid", 256'(tx_valid), 256'd0);
      check("async_rst_frame", tx_frame, 256'd0);
      user_valid = 1'b0; step(); rst_n = 1'b1;

      // refresh behaviour while paused with idle user side
      occ = 10'd800; tx_ready = 1'b1; step(); step();
      check("post_rst_fc_on", tx_frame, ON);
      check("post_rst_local_fc", 256'(local_fc), 256'd1);
      n_ref = 0;
      for (int c = 0; c < 100; c++) begin
         step();
         if (tx_valid) begin
            n_ref++;
            check("refresh_frame", tx_frame, ON);
         end
      end
`ifdef FC_REFRESH_EN
      exp_ref = 6;
`else
      exp_ref = 0;
`endif
      check("refresh_count", 256'(n_ref), 256'(exp_ref));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/local_fc_scheduler.md
Name: local_fc_scheduler

Overview:
- TX-side frame scheduler that generates the flow-control frames the link partner's remote-FC detector decodes.
- Watches local RX FIFO occupancy and applies hysteresis to decide XOFF/XON.
- Arbitrates one TX frame slot per cycle between these control frames and user data frames, with control frames taking priority.
- Sits between the user TX interface and the frame encoder/CRC stage, clocked on tx_frame_clk.

Parameters:
- FRAME_WIDTH, 256, frame width in bits; one frame per transfer.
- CRC_WIDTH, 12, width of the CRC field at the frame LSBs; the downstream stage fills it, this block drives zeros.
- OCC_WIDTH, 10, width of the RX FIFO occupancy input.
- HI_THRESH, 768, occupancy at or above which the block requests pause.
- LO_THRESH, 256, occupancy at or below which the block requests release; LO_THRESH < HI_THRESH is required.
- REFRESH_CYCLES, 4096, interval between re-sends of the current FC state; only used when FC_REFRESH_EN is defined.

Ports:
- tx_frame_clk, input, 1, the block's single clock.
- rst_n, input, 1, asynchronous active-low reset.
- rx_occupancy, input, OCC_WIDTH, local RX FIFO fill level.
- remote_fc, input, 1, partner pause request, already synchronised to tx_frame_clk; 1 blocks user data.
- user_frame, input, FRAME_WIDTH, user data frame with meta code already set in bits [FRAME_WIDTH-3:FRAME_WIDTH-4].
- user_valid, input, 1, user frame valid.
- user_ready, output, 1, user frame accepted when user_valid && user_ready.
- tx_frame, output, FRAME_WIDTH, frame to the encoder.
- tx_valid, output, 1, tx_frame valid.
- tx_ready, input, 1, encoder accepts the frame when tx_valid && tx_ready.
- local_fc, output, 1, last FC state actually transmitted: 1 = XOFF sent.

Behaviour:
- Reset values: tx_valid=0, tx_frame=0, local_fc=0, user_ready=0; FSM in RELEASED; refresh counter 0.
- Output stage:
  - Single register. load_en = !tx_valid || tx_ready.
  - tx_frame/tx_valid hold stable while tx_valid && !tx_ready.
  - Latency from selection to tx_valid is 1 cycle. No combinational path from user_valid to tx_valid.
- Control frame format:
  - Meta [FRAME_WIDTH-3:FRAME_WIDTH-4] = 2'b00.
  - Key in bits [CRC_WIDTH+7:CRC_WIDTH]: 8'h01 = FC_ON (pause), 8'h02 = FC_OFF (release).
  - All other bits 0.
- FSM states: RELEASED, PAUSE_PEND, PAUSED, RELEASE_PEND.
  - RELEASED -> PAUSE_PEND when rx_occupancy >= HI_THRESH.
  - PAUSE_PEND: send FC_ON when load_en. On the load cycle go to PAUSED and set local_fc=1.
  - PAUSED -> RELEASE_PEND when rx_occupancy <= LO_THRESH.
  - RELEASE_PEND: send FC_OFF when load_en. On the load cycle go to RELEASED and clear local_fc.
  - Occupancy between the thresholds: state holds (hysteresis).
- Latest wins:
  - PAUSE_PEND with occupancy <= LO_THRESH before the send: return to RELEASED, nothing sent.
  - RELEASE_PEND with occupancy >= HI_THRESH before the send: return to PAUSED, nothing sent.
- Arbitration per load_en cycle, priority order:
  1. Pending control frame.
  2. User frame: only if user_valid && !remote_fc.
  3. Nothing: tx_valid <= 0.
- user_ready = load_en && !ctrl_pending && !remote_fc. It is combinational from registered state plus tx_ready and remote_fc.
- remote_fc never blocks control frames. Deadlock avoidance: both ends are always able to send FC.
- A user frame already in the output register when remote_fc rises is still delivered; it is not revoked.
- Reset asserted mid-operation: the in-flight frame is dropped and all state returns to reset values immediately (asynchronous). After reset, the first FC_ON is sent only on a fresh threshold crossing.

Optional Feature:
- Macro: FC_REFRESH_EN.
- Defined:
  - The refresh counter runs in RELEASED and PAUSED and is cleared on every state change.
  - When it reaches REFRESH_CYCLES-1, one re-send of the current key is scheduled: FC_ON in PAUSED, FC_OFF in RELEASED.
  - The re-send uses control priority and does not change the FSM. The counter restarts on load.
  - If a threshold transition occurs while the refresh is pending, the transition's key replaces the refresh.
- Undefined: the counter and refresh logic are absent; control frames are sent only on transitions.

Test Plan:
- Ramp rx_occupancy 0→768, tx_ready=1 → exactly one frame with meta 00 and key 8'h01 one cycle after the crossing; local_fc=1. Ramp back to 256 → one key 8'h02 frame; local_fc=0. Values 257..767 produce nothing.
- Continuous user_valid with occupancy crossing 768 → user_ready=0 for one cycle, FC_ON inserted, user stream resumes. No user frame lost or duplicated (sequence check).
- tx_ready=0 for 5 cycles while FC_ON is pending and user_valid=1 → tx_frame held stable. FC_ON leaves first when tx_ready=1, then user frames.
- remote_fc=1 with user_valid=1 → no user frames; an occupancy crossing still emits FC_ON. remote_fc=0 → user frames flow the next cycle.
- Occupancy 800 then 200 within 3 cycles while tx_ready=0 → no control frame sent, local_fc stays 0. Assert rst_n=0 with tx_valid=1 → tx_valid=0 immediately.
- With FC_REFRESH_EN and REFRESH_CYCLES=16 in PAUSED, idle user → FC_ON re-sent every 16 cycles. Without the macro → no re-sends over 100 cycles.
